// File: rtl/srv_defs.sv
// Shared AHB-Lite encodings and data-memory controller types.
package srv_defs;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } dmem_state_t;

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case ({1'b0, size})
      HSIZE_BYTE: be = 4'b0001 << lane;
      HSIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/sram_1r1w.sv
// Synchronous word array: one byte-enabled write port, one registered read port.
module sram_1r1w #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Only the read register is reset; array contents survive reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ahb_dmem.sv
// AHB-Lite data-memory responder with byte-lane writes, wait states and
// two-cycle ERROR responses.
//
// state   | meaning
// --------+----------------------------------------------------
// ST_IDLE | no data phase pending, ready, OKAY
// ST_DATA | OKAY data phase, ready once the wait counter hits 0
// ST_ERR1 | first ERROR cycle, not ready
// ST_ERR2 | second ERROR cycle, ready
module ahb_dmem
  import srv_defs::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic        hwrite,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic        hmastlock,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [2:0]  WAIT_CNT   = 3'(WAIT_STATES);

  dmem_state_t   state, state_nxt, launch_state;
  logic [2:0]    cnt, cnt_nxt, launch_cnt;
  logic          ready_int;
  logic          accept, addr_err;
  logic [AW-1:0] a_word;
  logic [1:0]    a_lane, a_size;
  logic          a_write;
  logic          wr_commit, rd_en, fwd_hit;
  logic [3:0]    wr_be, fwd_mask;
  logic [31:0]   fwd_data, sram_rdata, fwd_bits;
  logic          unused_inputs;

  assign unused_inputs = ^{hburst, hprot, hmastlock, htrans[0]};

  // Gating with our own ready keeps a stray hready from starting a transfer mid-wait.
  assign accept = hsel & htrans[1] & hready & ready_int;

  always_comb begin
    addr_err = 1'b0;
    if (hsize > HSIZE_WORD)                          addr_err = 1'b1;
    if (hsize == HSIZE_HALF && haddr[0])             addr_err = 1'b1;
    if (hsize == HSIZE_WORD && haddr[1:0] != 2'b00)  addr_err = 1'b1;
    if ({1'b0, haddr} >= ADDR_LIMIT)                 addr_err = 1'b1;
  end

  assign launch_state = addr_err ? ST_ERR1 : ST_DATA;
  assign launch_cnt   = addr_err ? 3'd0 : WAIT_CNT;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = launch_state;
          cnt_nxt   = launch_cnt;
        end
      end
      ST_DATA: begin
        if (cnt != 3'd0) begin
          cnt_nxt = cnt - 3'd1;
        end else if (accept) begin
          state_nxt = launch_state;
          cnt_nxt   = launch_cnt;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ERR1: state_nxt = ST_ERR2;
      ST_ERR2: begin
        if (accept) begin
          state_nxt = launch_state;
          cnt_nxt   = launch_cnt;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_int = 1'b1;
    hresp     = HRESP_OKAY;
    case (state)
      ST_DATA: ready_int = (cnt == 3'd0);
      ST_ERR1: begin
        ready_int = 1'b0;
        hresp     = HRESP_ERROR;
      end
      ST_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  assign hreadyout = ready_int;

  assign wr_commit = (state == ST_DATA) && (cnt == 3'd0) && a_write;
  assign wr_be     = byte_enables(a_size, a_lane);
  assign rd_en     = accept & ~addr_err & ~hwrite;
  assign fwd_hit   = wr_commit && (a_word == haddr[AW+1:2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= 3'd0;
      a_word   <= '0;
      a_lane   <= 2'd0;
      a_size   <= 2'd0;
      a_write  <= 1'b0;
      fwd_mask <= 4'd0;
      fwd_data <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        a_word  <= haddr[AW+1:2];
        a_lane  <= haddr[1:0];
        a_size  <= hsize[1:0];
        a_write <= hwrite & ~addr_err;
      end
      // The array returns the pre-write word on a same-edge collision; patch it here.
      if (rd_en) begin
        fwd_mask <= fwd_hit ? wr_be : 4'd0;
        fwd_data <= hwdata;
      end
    end
  end

  sram_1r1w #(
    .DEPTH(DEPTH_WORDS),
    .AW   (AW)
  ) u_sram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wr_commit),
    .be   (wr_be),
    .waddr(a_word),
    .wdata(hwdata),
    .re   (rd_en),
    .raddr(haddr[AW+1:2]),
    .rdata(sram_rdata)
  );

  assign fwd_bits = {{8{fwd_mask[3]}}, {8{fwd_mask[2]}}, {8{fwd_mask[1]}}, {8{fwd_mask[0]}}};
  assign hrdata   = (sram_rdata & ~fwd_bits) | (fwd_data & fwd_bits);

endmodule

// File: tb/tb_ahb_dmem.sv
// Randomized and directed bench for ahb_dmem; two instances cover 0 and 3 wait states.
module tb_ahb_dmem;
  localparam int DEPTH = 256;
  localparam int WS1   = 3;
  localparam int MAXN  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int sel = 0;
  logic        hsel_bus = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'd0;
  logic        hwrite = 1'b0;
  logic [31:0] hwdata = '0;
  logic [2:0]  hburst = 3'd0;
  logic [3:0]  hprot = 4'd0;
  logic        hmastlock = 1'b0;

  logic hsel0, hsel1, hro0, hro1, hresp0, hresp1;
  logic [31:0] hrdata0, hrdata1;
  logic cur_ready, cur_resp;
  logic [31:0] cur_rdata;

  assign hsel0     = hsel_bus & (sel == 0);
  assign hsel1     = hsel_bus & (sel == 1);
  assign cur_ready = (sel == 0) ? hro0 : hro1;
  assign cur_resp  = (sel == 0) ? hresp0 : hresp1;
  assign cur_rdata = (sel == 0) ? hrdata0 : hrdata1;

  ahb_dmem #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .hsel(hsel0), .haddr(haddr), .htrans(htrans), .hsize(hsize),
    .hwrite(hwrite), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
    .hready(hro0), .hreadyout(hro0), .hresp(hresp0), .hrdata(hrdata0));

  ahb_dmem #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) dut1 (
    .clk(clk), .rst_n(rst_n), .hsel(hsel1), .haddr(haddr), .htrans(htrans), .hsize(hsize),
    .hwrite(hwrite), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
    .hready(hro1), .hreadyout(hro1), .hresp(hresp1), .hrdata(hrdata1));

  int checks = 0;
  int errors = 0;

  // Transfer list, observed results and model expectations.
  int          nq = 0;
  logic [31:0] q_addr [MAXN];
  logic [2:0]  q_size [MAXN];
  logic        q_write[MAXN];
  logic [31:0] q_wdata[MAXN];
  logic [31:0] r_rdata[MAXN];
  logic        r_resp [MAXN];
  int          r_low  [MAXN];
  int          r_lowerr[MAXN];
  bit          r_done [MAXN];
  logic [31:0] e_rdata[MAXN];
  logic        e_resp [MAXN];
  int          e_low  [MAXN];

  logic [31:0] mdl [2][DEPTH];
  logic [31:0] last_rd [2];

  task automatic push(input logic [31:0] a, input logic [2:0] s, input logic w, input logic [31:0] d);
    q_addr[nq] = a; q_size[nq] = s; q_write[nq] = w; q_wdata[nq] = d;
    nq++;
  endtask

  // Memory as a plain word array; a transfer is a sequence of byte updates.
  function automatic void model_xfer(input int k);
    longint unsigned a;
    bit err;
    int nbytes, lane, w;
    a = q_addr[k];
    err = (q_size[k] > 2) || (q_size[k] == 1 && (a % 2) != 0) ||
          (q_size[k] == 2 && (a % 4) != 0) || (a >= 4 * DEPTH);
    e_resp[k] = err;
    e_low[k]  = err ? 1 : ((sel == 0) ? 0 : WS1);
    if (!err) begin
      w = int'(a / 4);
      lane = int'(a % 4);
      nbytes = 1 << q_size[k];
      if (q_write[k]) begin
        for (int b = lane; b < lane + nbytes; b++) mdl[sel][w][8*b +: 8] = q_wdata[k][8*b +: 8];
      end else begin
        last_rd[sel] = mdl[sel][w];
      end
    end
    e_rdata[k] = last_rd[sel];
  endfunction

  // Issues the queued transfers fully pipelined; starts and ends at a negedge.
  task automatic run_seq();
    int issued = 0;
    int dp = -1;
    int nxt;
    int lowc = 0;
    int guard = 0;
    logic ro;
    for (int k = 0; k < nq; k++) begin
      model_xfer(k);
      r_done[k] = 1'b0; r_lowerr[k] = 0; r_low[k] = -1; r_resp[k] = 1'bx; r_rdata[k] = 'x;
    end
    while ((issued < nq || dp >= 0) && guard < 400) begin
      guard++;
      ro = cur_ready;
      nxt = dp;
      if (dp >= 0) begin
        if (!ro) begin
          lowc++;
          if (cur_resp) r_lowerr[dp]++;
        end else begin
          r_rdata[dp] = cur_rdata; r_resp[dp] = cur_resp; r_low[dp] = lowc; r_done[dp] = 1'b1;
          nxt = -1;
        end
        hwdata = q_wdata[dp];
      end
      if (ro) begin
        if (issued < nq) begin
          hsel_bus = 1'b1; htrans = 2'b10; haddr = q_addr[issued];
          hsize = q_size[issued]; hwrite = q_write[issued];
          nxt = issued; issued++; lowc = 0;
        end else begin
          hsel_bus = 1'b0; htrans = 2'b00;
        end
      end
      dp = nxt;
      @(posedge clk);
      @(negedge clk);
    end
    hsel_bus = 1'b0; htrans = 2'b00;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (hro0 !== 1'b1 || hresp0 !== 1'b0 || hrdata0 !== 32'h0) begin
      errors++;
      $display("FAIL reset_dut0 got ready=%b resp=%b rdata=%h want 1 0 00000000", hro0, hresp0, hrdata0);
    end
    checks++;
    if (hro1 !== 1'b1 || hresp1 !== 1'b0 || hrdata1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_dut1 got ready=%b resp=%b rdata=%h want 1 0 00000000", hro1, hresp1, hrdata1);
    end
    rst_n = 1'b1;
    last_rd[0] = '0; last_rd[1] = '0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs[11];
    for (int i = 0; i < 8; i++) addrs[i] = 32'h80 + 32'(4 * i);
    addrs[8] = 32'h20; addrs[9] = 32'h30; addrs[10] = 32'h40;
    for (int s = 0; s < 2; s++) begin
      sel = s; nq = 0;
      for (int i = 0; i < 11; i++) push(addrs[i], 3'd2, 1'b1, $urandom);
      for (int i = 0; i < 11; i++) push(addrs[i], 3'd2, 1'b0, $urandom);
      run_seq();
      for (int k = 0; k < nq; k++) begin
        checks++;
        if (!r_done[k] || r_resp[k] !== e_resp[k] || r_low[k] != e_low[k] || r_lowerr[k] != (e_resp[k] ? 1 : 0) || r_rdata[k] !== e_rdata[k]) begin
          errors++;
          $display("FAIL back_to_back[%0d.%0d] got done=%0b resp=%b low=%0d lowerr=%0d rdata=%h want resp=%b low=%0d rdata=%h",
                   s, k, r_done[k], r_resp[k], r_low[k], r_lowerr[k], r_rdata[k], e_resp[k], e_low[k], e_rdata[k]);
        end
      end
    end
  endtask

  task automatic test_word_rw();
    sel = 0; nq = 0;
    push(32'h10, 3'd2, 1'b1, 32'hDEADBEEF);
    push(32'h10, 3'd2, 1'b0, $urandom);
    run_seq();
    for (int k = 0; k < nq; k++) begin
      checks++;
      if (!r_done[k] || r_resp[k] !== e_resp[k] || r_low[k] != e_low[k] || r_lowerr[k] != (e_resp[k] ? 1 : 0) || r_rdata[k] !== e_rdata[k]) begin
        errors++;
        $display("FAIL word_rw[%0d] got done=%0b resp=%b low=%0d rdata=%h want resp=%b low=%0d rdata=%h",
                 k, r_done[k], r_resp[k], r_low[k], r_rdata[k], e_resp[k], e_low[k], e_rdata[k]);
      end
    end
    checks++;
    if (r_rdata[1] !== 32'hDEADBEEF || r_low[1] != 0) begin
      errors++;
      $display("FAIL word_rw_value got rdata=%h low=%0d want deadbeef 0", r_rdata[1], r_low[1]);
    end
  endtask

  task automatic test_byte_half();
    sel = 0; nq = 0;
    push(32'h20, 3'd0, 1'b1, {4{8'h11}});
    push(32'h21, 3'd0, 1'b1, {4{8'h22}});
    push(32'h22, 3'd0, 1'b1, {4{8'h33}});
    push(32'h23, 3'd0, 1'b1, {4{8'h44}});
    push(32'h20, 3'd2, 1'b0, $urandom);
    push(32'h22, 3'd1, 1'b1, {2{16'hABCD}});
    push(32'h20, 3'd2, 1'b0, $urandom);
    run_seq();
    for (int k = 0; k < nq; k++) begin
      checks++;
      if (!r_done[k] || r_resp[k] !== e_resp[k] || r_low[k] != e_low[k] || r_lowerr[k] != (e_resp[k] ? 1 : 0) || r_rdata[k] !== e_rdata[k]) begin
        errors++;
        $display("FAIL byte_half[%0d] got done=%0b resp=%b low=%0d rdata=%h want resp=%b low=%0d rdata=%h",
                 k, r_done[k], r_resp[k], r_low[k], r_rdata[k], e_resp[k], e_low[k], e_rdata[k]);
      end
    end
    checks++;
    if (r_rdata[4] !== 32'h44332211 || r_rdata[6] !== 32'hABCD2211) begin
      errors++;
      $display("FAIL byte_half_value got %h %h want 44332211 abcd2211", r_rdata[4], r_rdata[6]);
    end
  endtask

  task automatic test_forwarding();
    sel = 0; nq = 0;
    push(32'h30, 3'd2, 1'b1, 32'h12345678);
    push(32'h30, 3'd2, 1'b0, $urandom);
    push(32'h30, 3'd2, 1'b1, 32'h0000FFFF);
    push(32'h32, 3'd1, 1'b0, $urandom);
    push(32'h31, 3'd0, 1'b1, 32'hAAAAAAAA);
    push(32'h30, 3'd0, 1'b0, $urandom);
    run_seq();
    for (int k = 0; k < nq; k++) begin
      checks++;
      if (!r_done[k] || r_resp[k] !== e_resp[k] || r_low[k] != e_low[k] || r_lowerr[k] != (e_resp[k] ? 1 : 0) || r_rdata[k] !== e_rdata[k]) begin
        errors++;
        $display("FAIL forwarding[%0d] got done=%0b resp=%b low=%0d rdata=%h want resp=%b low=%0d rdata=%h",
                 k, r_done[k], r_resp[k], r_low[k], r_rdata[k], e_resp[k], e_low[k], e_rdata[k]);
      end
    end
    checks++;
    if (r_rdata[3] !== 32'h0000FFFF || r_rdata[5] !== 32'h0000AAFF) begin
      errors++;
      $display("FAIL forwarding_value got %h %h want 0000ffff 0000aaff", r_rdata[3], r_rdata[5]);
    end
  endtask

  task automatic test_errors();
    sel = 0; nq = 0;
    push(32'h3FC, 3'd2, 1'b1, 32'h600DF00D);
    push(32'h41, 3'd1, 1'b1, $urandom);
    push(32'h42, 3'd2, 1'b1, $urandom);
    push(32'h400, 3'd2, 1'b1, $urandom);
    push(32'h40, 3'd3, 1'b0, $urandom);
    push(32'h40, 3'd2, 1'b0, $urandom);
    push(32'h3FC, 3'd2, 1'b0, $urandom);
    push(32'h400, 3'd2, 1'b0, $urandom);
    run_seq();
    for (int k = 0; k < nq; k++) begin
      checks++;
      if (!r_done[k] || r_resp[k] !== e_resp[k] || r_low[k] != e_low[k] || r_lowerr[k] != (e_resp[k] ? 1 : 0) || r_rdata[k] !== e_rdata[k]) begin
        errors++;
        $display("FAIL errors[%0d] got done=%0b resp=%b low=%0d lowerr=%0d rdata=%h want resp=%b low=%0d rdata=%h",
                 k, r_done[k], r_resp[k], r_low[k], r_lowerr[k], r_rdata[k], e_resp[k], e_low[k], e_rdata[k]);
      end
    end
    checks++;
    if (r_rdata[6] !== 32'h600DF00D || r_resp[3] !== 1'b1) begin
      errors++;
      $display("FAIL errors_boundary got rdata=%h resp=%b want 600df00d 1", r_rdata[6], r_resp[3]);
    end
  endtask

  task automatic test_wait_states();
    sel = 1; nq = 0;
    push(32'h10, 3'd2, 1'b1, 32'hCAFEF00D);
    push(32'h10, 3'd2, 1'b0, $urandom);
    push(32'h10, 3'd2, 1'b0, $urandom);
    run_seq();
    for (int k = 0; k < nq; k++) begin
      checks++;
      if (!r_done[k] || r_resp[k] !== e_resp[k] || r_low[k] != e_low[k] || r_lowerr[k] != (e_resp[k] ? 1 : 0) || r_rdata[k] !== e_rdata[k]) begin
        errors++;
        $display("FAIL wait_states[%0d] got done=%0b resp=%b low=%0d rdata=%h want resp=%b low=%0d rdata=%h",
                 k, r_done[k], r_resp[k], r_low[k], r_rdata[k], e_resp[k], e_low[k], e_rdata[k]);
      end
    end
    checks++;
    if (r_low[2] != 3 || r_rdata[2] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL wait_reload got low=%0d rdata=%h want 3 cafef00d", r_low[2], r_rdata[2]);
    end
  endtask

  task automatic test_reset_midwrite();
    sel = 1;
    hsel_bus = 1'b1; htrans = 2'b10; haddr = 32'h10; hsize = 3'd2; hwrite = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hsel_bus = 1'b0; htrans = 2'b00; hwdata = 32'h5555AAAA;
    checks++;
    if (hro1 !== 1'b0) begin
      errors++;
      $display("FAIL midwrite_waiting got ready=%b want 0", hro1);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (hro1 !== 1'b1 || hresp1 !== 1'b0 || hrdata1 !== 32'h0) begin
      errors++;
      $display("FAIL midwrite_abort got ready=%b resp=%b rdata=%h want 1 0 00000000", hro1, hresp1, hrdata1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_rd[0] = '0; last_rd[1] = '0;
    @(negedge clk);
    nq = 0;
    push(32'h10, 3'd2, 1'b0, $urandom);
    run_seq();
    checks++;
    if (!r_done[0] || r_rdata[0] !== e_rdata[0] || r_rdata[0] !== 32'hCAFEF00D || r_low[0] != 3) begin
      errors++;
      $display("FAIL midwrite_unchanged got done=%0b rdata=%h low=%0d want cafef00d 3", r_done[0], r_rdata[0], r_low[0]);
    end
  endtask

  task automatic test_random();
    int r;
    logic [31:0] a;
    logic [2:0] s;
    for (int sidx = 0; sidx < 2; sidx++) begin
      sel = sidx;
      for (int round = 0; round < 3; round++) begin
        nq = 0;
        for (int i = 0; i < 24; i++) begin
          r = int'($urandom_range(0, 9));
          s = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
          r = int'($urandom_range(0, 15));
          a = (r == 0) ? 32'h400 + 32'($urandom_range(0, 15)) :
              (r == 1) ? 32'hFFFFFFFC : 32'h80 + 32'($urandom_range(0, 31));
          push(a, s, 1'($urandom_range(0, 1)), $urandom);
        end
        run_seq();
        for (int k = 0; k < nq; k++) begin
          checks++;
          if (!r_done[k] || r_resp[k] !== e_resp[k] || r_low[k] != e_low[k] || r_lowerr[k] != (e_resp[k] ? 1 : 0) || r_rdata[k] !== e_rdata[k]) begin
            errors++;
            $display("FAIL random[%0d.%0d.%0d] addr=%h size=%0d wr=%b got done=%0b resp=%b low=%0d lowerr=%0d rdata=%h want resp=%b low=%0d rdata=%h",
                     sidx, round, k, q_addr[k], q_size[k], q_write[k], r_done[k], r_resp[k], r_low[k], r_lowerr[k], r_rdata[k],
                     e_resp[k], e_low[k], e_rdata[k]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_word_rw();
    test_byte_half();
    test_forwarding();
    test_errors();
    test_wait_states();
    test_reset_midwrite();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
